// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair. Results are computed
// at the accept edge into a temp pair and committed after a fixed busy window.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [3:0]  md_op,
    input  logic        md_flush,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    output logic        md_busy,
    output logic        md_stall,
    output logic [31:0] md_hi,
    output logic [31:0] md_lo,
    output logic [31:0] md_rdata,
    output logic [1:0]  dbg_state_o
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
    logic             tmp_we_q, tmp_we_d;

    logic        accept;
    logic        op_is_md;
    logic        op_is_long;
    logic [63:0] prod_s, prod_u;
    logic        is_signed_div, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, dvd, dvs, dvs_safe, uq, ur, quot, rem;

    // Signed product uses sign-extended operands; the low 64 bits are exact.
    assign prod_s = {{32{md_a[31]}}, md_a} * {{32{md_b[31]}}, md_b};
    assign prod_u = {32'b0, md_a} * {32'b0, md_b};

    // One unsigned divider on magnitudes serves both div and divu; signs are
    // restored afterwards so INT_MIN / -1 falls out as 0x80000000 with rem 0.
    assign is_signed_div = (md_op == OP_DIV);
    assign a_neg         = md_a[31];
    assign b_neg         = md_b[31];
    assign a_mag         = a_neg ? (32'd0 - md_a) : md_a;
    assign b_mag         = b_neg ? (32'd0 - md_b) : md_b;
    assign dvd           = is_signed_div ? a_mag : md_a;
    assign dvs           = is_signed_div ? b_mag : md_b;
    assign dvs_safe      = (dvs == 32'd0) ? 32'd1 : dvs;
    assign uq            = dvd / dvs_safe;
    assign ur            = dvd % dvs_safe;
    assign quot          = (is_signed_div && (a_neg ^ b_neg)) ? (32'd0 - uq) : uq;
    assign rem           = (is_signed_div && a_neg) ? (32'd0 - ur) : ur;

    assign op_is_md   = (md_op >= OP_MULT) && (md_op <= OP_MTLO);
    assign op_is_long = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign md_busy    = (state_q != S_IDLE);
    assign accept     = md_start & ~md_flush & ~md_busy & op_is_md;
    assign md_stall   = md_start & (md_busy | (~md_flush & op_is_long));

    assign md_hi       = hi_q;
    assign md_lo       = lo_q;
    assign dbg_state_o = state_q;

    always_comb begin
        md_rdata = 32'd0;
        if (md_op == OP_MFHI) begin
            md_rdata = hi_q;
        end else if (md_op == OP_MFLO) begin
            md_rdata = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            tmp_hi_q <= 32'd0;
            tmp_lo_q <= 32'd0;
            tmp_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            tmp_we_q <= tmp_we_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        tmp_we_d = tmp_we_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (md_op)
                        OP_MULT: begin
                            {tmp_hi_d, tmp_lo_d} = prod_s;
                            tmp_we_d = 1'b1;
                            cnt_d    = MULT_N;
                            state_d  = S_MULT;
                        end
                        OP_MULTU: begin
                            {tmp_hi_d, tmp_lo_d} = prod_u;
                            tmp_we_d = 1'b1;
                            cnt_d    = MULT_N;
                            state_d  = S_MULT;
                        end
                        OP_DIV, OP_DIVU: begin
                            tmp_hi_d = rem;
                            tmp_lo_d = quot;
                            // A zero divisor still burns the busy window but commits nothing.
                            tmp_we_d = (md_b != 32'd0);
                            cnt_d    = DIV_N;
                            state_d  = S_DIV;
                        end
                        OP_MTHI: hi_d = md_a;
                        OP_MTLO: lo_d = md_a;
                        default: ;
                    endcase
                end
            end
            S_MULT, S_DIV: begin
                if (cnt_q == CNT_ONE) begin
                    if (tmp_we_q) begin
                        hi_d = tmp_hi_q;
                        lo_d = tmp_lo_q;
                    end
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random ops, checked by a
// commit-time scoreboard fed from a transaction-level HI/LO model.
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_start;
    logic [3:0]  md_op;
    logic        md_flush;
    logic [31:0] md_a, md_b;
    logic        md_busy, md_stall;
    logic [31:0] md_hi, md_lo, md_rdata;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .md_start(md_start), .md_op(md_op),
        .md_flush(md_flush), .md_a(md_a), .md_b(md_b), .md_busy(md_busy),
        .md_stall(md_stall), .md_hi(md_hi), .md_lo(md_lo), .md_rdata(md_rdata),
        .dbg_state_o(dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Expected {HI,LO} at each commit, with the busy length that must precede it.
    logic [63:0] exp_q[$];
    int          len_q[$];
    // Pending mthi/mtlo writes: bit 32 selects HI.
    logic [32:0] mt_q[$];

    // Visible model (monitor-owned) and architectural-after-pending model (driver-owned).
    logic [31:0] vis_hi = 32'd0, vis_lo = 32'd0;
    logic [31:0] arch_hi = 32'd0, arch_lo = 32'd0;
    int          free_edge = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_calc(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] cur);
        int              ia, ib;
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     res, qv, rv;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        ua = {32'b0, a};
        ub = {32'b0, b};
        res = cur;
        case (op)
            4'd1: res = sa * sb;
            4'd2: res = ua * ub;
            4'd3: if (b != 32'd0) begin
                q = sa / sb;
                r = sa % sb;
                qv = q;
                rv = r;
                res = {rv[31:0], qv[31:0]};
            end
            4'd4: if (b != 32'd0) begin
                qv = ua / ub;
                rv = ua % ub;
                res = {rv[31:0], qv[31:0]};
            end
            default: ;
        endcase
        return res;
    endfunction

    // Monitor: pops at each busy->idle transition and tracks HI/LO every cycle.
    logic        mon_prev_busy = 1'b0;
    int          mon_cnt = 0;
    always @(negedge clk) begin
        logic [63:0] e;
        logic [32:0] m;
        int          l;
        if (reset) begin
            mon_prev_busy = 1'b0;
            mon_cnt = 0;
            exp_q.delete();
            len_q.delete();
            mt_q.delete();
            vis_hi = 32'd0;
            vis_lo = 32'd0;
        end else begin
            while (mt_q.size() != 0) begin
                m = mt_q.pop_front();
                if (m[32]) vis_hi = m[31:0];
                else       vis_lo = m[31:0];
            end
            if (md_busy) begin
                mon_cnt++;
            end else if (mon_prev_busy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_commit: busy ended after %0d cycles, expected no op", mon_cnt);
                end else begin
                    e = exp_q.pop_front();
                    l = len_q.pop_front();
                    vis_hi = e[63:32];
                    vis_lo = e[31:0];
                    check("busy_len", 32'(mon_cnt), 32'(l));
                end
                mon_cnt = 0;
            end
            mon_prev_busy = md_busy;
            check("hi", md_hi, vis_hi);
            check("lo", md_lo, vis_lo);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1ns after a posedge; holds the op for one cycle.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        logic        busy_m, acc, stall_e;
        logic [31:0] rd_e;
        logic [63:0] r;
        busy_m  = (cyc + 1 < free_edge);
        acc     = !busy_m && !fl && (op >= 4'd1) && (op <= 4'd6);
        stall_e = busy_m || (!fl && (op >= 4'd1) && (op <= 4'd4));
        rd_e    = (op == 4'd7) ? arch_hi : (op == 4'd8) ? arch_lo : 32'd0;
        md_start = 1'b1;
        md_op    = op;
        md_a     = a;
        md_b     = b;
        md_flush = fl;
        @(negedge clk);
        check("stall", 32'(md_stall), 32'(stall_e));
        if (!busy_m) check("rdata", md_rdata, rd_e);
        @(posedge clk);
        #1;
        md_start = 1'b0;
        md_op    = 4'd0;
        md_flush = 1'b0;
        if (acc) begin
            if (op <= 4'd4) begin
                r = ref_calc(op, a, b, {arch_hi, arch_lo});
                exp_q.push_back(r);
                len_q.push_back((op <= 4'd2) ? MULT_N : DIV_N);
                {arch_hi, arch_lo} = r;
                free_edge = cyc + ((op <= 4'd2) ? MULT_N : DIV_N) + 1;
            end else if (op == 4'd5) begin
                arch_hi = a;
                mt_q.push_back({1'b1, a});
            end else begin
                arch_lo = a;
                mt_q.push_back({1'b0, a});
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((cyc + 1 < free_edge) && (n < 100)) begin
            step(1);
            n++;
        end
        check("idle_busy", 32'(md_busy), 32'd0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        md_start = 1'b0;
        step(1);
        reset     = 1'b0;
        arch_hi   = 32'd0;
        arch_lo   = 32'd0;
        free_edge = 0;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        md_start = 1'b0;
        md_op    = 4'd0;
        md_flush = 1'b0;
        md_a     = 32'd0;
        md_b     = 32'd0;
        step(3);
        reset = 1'b0;
        step(1);
        check("rst_busy", 32'(md_busy), 32'd0);
        check("rst_hi", md_hi, 32'd0);
        check("rst_lo", md_lo, 32'd0);

        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_idle();
        check("mult_hi", md_hi, 32'hFFFF_FFFF);
        check("mult_lo", md_lo, 32'hFFFF_FFFA);

        issue(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_idle();
        check("multu_hi", md_hi, 32'h0000_0002);
        check("multu_lo", md_lo, 32'hFFFF_FFFA);

        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle();
        check("div_lo", md_lo, 32'hFFFF_FFFD);
        check("div_hi", md_hi, 32'hFFFF_FFFF);
        issue(4'd4, 32'd7, 32'd0, 1'b0);
        wait_idle();
        check("div0_hi", md_hi, 32'hFFFF_FFFF);
        check("div0_lo", md_lo, 32'hFFFF_FFFD);

        issue(4'd5, 32'h0000_1234, 32'd0, 1'b0);
        check("mthi_busy", 32'(md_busy), 32'd0);
        check("mthi_hi", md_hi, 32'h0000_1234);
        issue(4'd7, 32'd0, 32'd0, 1'b0);
        issue(4'd6, 32'hDEAD_BEEF, 32'd0, 1'b1);
        check("mtlo_flush_lo", md_lo, 32'hFFFF_FFFD);
        issue(4'd8, 32'd0, 32'd0, 1'b0);

        issue(4'd3, 32'd100, 32'd7, 1'b0);
        issue(4'd1, 32'd5, 32'd5, 1'b0);
        step(1);
        do_reset();
        check("rst_mid_busy", 32'(md_busy), 32'd0);
        check("rst_mid_hi", md_hi, 32'd0);
        check("rst_mid_lo", md_lo, 32'd0);
        step(14);

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
        check("ovf_lo", md_lo, 32'h8000_0000);
        check("ovf_hi", md_hi, 32'd0);
        issue(4'd1, 32'd6, 32'hFFFF_FFF9, 1'b0);
        check("b2b_busy", 32'(md_busy), 32'd1);
        wait_idle();
        check("b2b_lo", md_lo, 32'hFFFF_FFD6);

        for (int i = 0; i < 80; i++) begin
            issue(4'($urandom_range(0, 8)), rand_operand(), rand_operand(),
                  ($urandom_range(0, 7) == 0));
            step($urandom_range(0, 12));
        end
        wait_idle();
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
